// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and RAM-controller-side handshake signals for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16
);
  logic              init_req;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_wdata;
  logic              init_done;

  logic              exe_req;
  logic              exe_we;
  logic [ADDR_W-1:0] exe_addr;
  logic [DATA_W-1:0] exe_wdata;
  logic              exe_done;
  logic [DATA_W-1:0] exe_rdata;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  init_req, init_addr, init_wdata,
    input  exe_req, exe_we, exe_addr, exe_wdata,
    input  if_req, if_addr,
    input  mem_done, mem_rdata,
    output init_done, exe_done, if_done, exe_rdata, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output init_req, init_addr, init_wdata,
    output exe_req, exe_we, exe_addr, exe_wdata,
    output if_req, if_addr,
    output mem_done, mem_rdata,
    input  init_done, exe_done, if_done, exe_rdata, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority arbiter (init > exe > if, with IF anti-starvation) sequencing one
// single-port RAM through a registered req/done handshake with a hang timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned TIMEOUT      = 15,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_port_arbiter_if.slave    bus,
  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic                 timeout_err_o
);

  localparam int unsigned WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SCNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_INIT = 2'b01;
  localparam logic [1:0] G_EXE  = 2'b10;
  localparam logic [1:0] G_IF   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                terr_q, terr_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                init_done_q, init_done_d;
  logic                exe_done_q, exe_done_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   exe_rdata_q, exe_rdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SCNT_W-1:0]   starve_q, starve_d;

  logic [1:0]          win;
  logic [DATA_W-1:0]   rsp_data;
  logic                starve_full;

  assign starve_full = (starve_q == SCNT_W'(STARVE_LIMIT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    terr_d      = terr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    init_done_d = 1'b0;
    exe_done_d  = 1'b0;
    if_done_d   = 1'b0;
    exe_rdata_d = exe_rdata_q;
    if_rdata_d  = if_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    win         = G_NONE;
    rsp_data    = bus.mem_rdata;

    unique case (state_q)
      S_IDLE: begin
        if (bus.init_req) begin
          win = G_INIT;
        end else if (bus.if_req && bus.exe_req && starve_full) begin
          win = G_IF;
        end else if (bus.exe_req) begin
          win = G_EXE;
        end else if (bus.if_req) begin
          win = G_IF;
        end

        if (win != G_NONE) begin
          state_d    = S_WAIT;
          grant_d    = win;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          wait_cnt_d = '0;
          case (win)
            G_INIT: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = bus.init_addr;
              mem_wdata_d = bus.init_wdata;
            end
            G_EXE: begin
              mem_we_d    = bus.exe_we;
              mem_addr_d  = bus.exe_addr;
              mem_wdata_d = bus.exe_wdata;
            end
            default: begin
              mem_we_d    = 1'b0;
              mem_addr_d  = bus.if_addr;
              mem_wdata_d = '0;
            end
          endcase
          // An init grant with IF pending leaves the starvation count untouched.
          if (win == G_EXE && bus.if_req) begin
            if (!starve_full) starve_d = starve_q + SCNT_W'(1);
          end else if (win == G_IF || !bus.if_req) begin
            starve_d = '0;
          end
        end
      end

      S_WAIT: begin
        if (bus.mem_done || wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          wait_cnt_d = '0;
          if (!bus.mem_done) begin
            rsp_data = '1;
            terr_d   = 1'b1;
          end
          case (grant_q)
            G_INIT: init_done_d = 1'b1;
            G_EXE: begin
              exe_done_d = 1'b1;
              if (!mem_we_q) exe_rdata_d = rsp_data;
            end
            G_IF: begin
              if_done_d  = 1'b1;
              if_rdata_d = rsp_data;
            end
            default: ;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      init_done_q <= 1'b0;
      exe_done_q  <= 1'b0;
      if_done_q   <= 1'b0;
      exe_rdata_q <= '0;
      if_rdata_q  <= '0;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      init_done_q <= init_done_d;
      exe_done_q  <= exe_done_d;
      if_done_q   <= if_done_d;
      exe_rdata_q <= exe_rdata_d;
      if_rdata_q  <= if_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.init_done  = init_done_q;
  assign bus.exe_done   = exe_done_q;
  assign bus.if_done    = if_done_q;
  assign bus.exe_rdata  = exe_rdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign grant_o        = grant_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = terr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected issues/completions are queued by the
// stimulus; a negedge monitor pops and compares whenever the DUT issues or completes.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] G_INIT = 2'b01;
  localparam logic [1:0] G_EXE  = 2'b10;
  localparam logic [1:0] G_IF   = 2'b11;

  typedef struct {
    logic [1:0]        g;
    logic              we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    int                len;
  } iss_t;

  typedef struct {
    logic [1:0]        g;
    logic              chk;
    logic [DATA_W-1:0] rd;
    logic              terr;
  } cpl_t;

  logic clk;
  logic rst_n;
  logic [1:0] grant;
  logic busy;
  logic timeout_err;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15), .STARVE_LIMIT(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus),
    .grant_o(grant), .busy_o(busy), .timeout_err_o(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  iss_t iss_q[$];
  cpl_t cpl_q[$];
  int errors;
  int checks;
  int resp_delay;
  logic [DATA_W-1:0] resp_data;
  int spur_req;
  int spur_seen;
  bit spur_resp;
  logic [DATA_W-1:0] exp_exe;
  logic [DATA_W-1:0] exp_if;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_iss(input logic [1:0] g, input logic we,
                                   input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                   input int len);
    iss_t it;
    it.g = g; it.we = we; it.a = a; it.d = d; it.len = len;
    iss_q.push_back(it);
  endfunction

  function automatic void push_cpl(input logic [1:0] g, input logic chk,
                                   input logic [DATA_W-1:0] rd, input logic terr);
    cpl_t c;
    c.g = g; c.chk = chk; c.rd = rd; c.terr = terr;
    cpl_q.push_back(c);
  endfunction

  // RAM controller model: answers after resp_delay request cycles, plus spurious pulses.
  task automatic responder();
    int rc = 0;
    forever begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      if (bus.mem_req) rc++; else rc = 0;
      if (bus.mem_req && resp_delay != 0 && rc == resp_delay) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = resp_data;
      end
      if (spur_req != spur_seen) begin
        spur_seen     = spur_req;
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h5A5A;
      end
      if (spur_resp && (bus.init_done || bus.exe_done || bus.if_done)) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = 16'h5A5A;
      end
    end
  endtask

  task automatic monitor();
    logic prev_req = 1'b0;
    int   hi = 0;
    int   nd;
    iss_t cur;
    cpl_t c;
    logic [1:0] g;
    cur.len = -1; cur.g = '0; cur.we = 1'b0; cur.a = '0; cur.d = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev_req) begin
        check("issue_expected", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          cur = iss_q.pop_front();
          check("issue_grant", 32'(grant), 32'(cur.g));
          check("issue_we", 32'(bus.mem_we), 32'(cur.we));
          check("issue_addr", 32'(bus.mem_addr), 32'(cur.a));
          if (cur.g != G_IF) check("issue_wdata", 32'(bus.mem_wdata), 32'(cur.d));
          check("issue_busy", 32'(busy), 32'd1);
        end
        hi = 1;
      end else if (bus.mem_req) begin
        hi++;
        check("hold_addr", 32'(bus.mem_addr), 32'(cur.a));
        check("hold_grant", 32'(grant), 32'(cur.g));
      end else if (prev_req && cur.len >= 0) begin
        check("req_cycles", 32'(hi), 32'(cur.len));
      end

      nd = int'(bus.init_done) + int'(bus.exe_done) + int'(bus.if_done);
      if (nd != 0) begin
        check("one_done", 32'(nd), 32'd1);
        check("done_expected", 32'(cpl_q.size() != 0), 32'd1);
        if (cpl_q.size() != 0) begin
          c = cpl_q.pop_front();
          g = bus.if_done ? G_IF : (bus.exe_done ? G_EXE : G_INIT);
          check("done_port", 32'(g), 32'(c.g));
          check("done_grant", 32'(grant), 32'(c.g));
          check("done_req_low", 32'(bus.mem_req), 32'd0);
          check("done_after_req", 32'(prev_req), 32'd1);
          check("done_terr", 32'(timeout_err), 32'(c.terr));
          if (c.chk) begin
            if (c.g == G_EXE) exp_exe = c.rd;
            else exp_if = c.rd;
          end
          check("exe_rdata", 32'(bus.exe_rdata), 32'(exp_exe));
          check("if_rdata", 32'(bus.if_rdata), 32'(exp_if));
        end
      end
      prev_req = bus.mem_req;
    end
  endtask

  task automatic run_init(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit seen = 1'b0;
    @(negedge clk);
    bus.init_req = 1'b1; bus.init_addr = a; bus.init_wdata = d;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = bus.init_done;
    end
    bus.init_req = 1'b0;
    check("init_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_exe(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit seen = 1'b0;
    @(negedge clk);
    bus.exe_req = 1'b1; bus.exe_we = we; bus.exe_addr = a; bus.exe_wdata = d;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = bus.exe_done;
    end
    bus.exe_req = 1'b0;
    check("exe_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic run_if(input logic [ADDR_W-1:0] a);
    bit seen = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = a;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = bus.if_done;
    end
    bus.if_req = 1'b0;
    check("if_done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    errors = 0; checks = 0;
    resp_delay = 1; resp_data = '0;
    spur_req = 0; spur_seen = 0; spur_resp = 1'b0;
    exp_exe = '0; exp_if = '0;
    bus.init_req = 1'b0; bus.init_addr = '0; bus.init_wdata = '0;
    bus.exe_req = 1'b0; bus.exe_we = 1'b0; bus.exe_addr = '0; bus.exe_wdata = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.mem_done = 1'b0; bus.mem_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    fork
      responder();
      monitor();
    join_none

    // Reset state
    @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_bus", 32'({bus.mem_we, bus.mem_addr}), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_dones", 32'({bus.init_done, bus.exe_done, bus.if_done}), 32'd0);
    check("rst_rdata", {bus.exe_rdata, bus.if_rdata}, 32'd0);
    check("rst_status", 32'({grant, busy, timeout_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single IF read
    resp_delay = 1; resp_data = 16'hBEEF;
    push_iss(G_IF, 1'b0, 18'h00123, 16'h0000, 1);
    push_cpl(G_IF, 1'b1, 16'hBEEF, 1'b0);
    run_if(18'h00123);

    // Simultaneous init, exe read and IF read: served init, exe, if
    resp_delay = 2; resp_data = 16'hCAFE;
    push_iss(G_INIT, 1'b1, 18'h00010, 16'h1111, 2);
    push_iss(G_EXE, 1'b0, 18'h20000, 16'h2222, 2);
    push_iss(G_IF, 1'b0, 18'h00300, 16'h0000, 2);
    push_cpl(G_INIT, 1'b0, 16'h0000, 1'b0);
    push_cpl(G_EXE, 1'b1, 16'hCAFE, 1'b0);
    push_cpl(G_IF, 1'b1, 16'hCAFE, 1'b0);
    fork
      run_init(18'h00010, 16'h1111);
      run_exe(1'b0, 18'h20000, 16'h2222);
      run_if(18'h00300);
    join

    // Starvation: four EXE grants, then IF, then EXE resumes
    resp_delay = 1; resp_data = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      push_iss(G_EXE, 1'b0, 18'(32'h100 + i), 16'h0000, 1);
      push_cpl(G_EXE, 1'b1, 16'h1234, 1'b0);
    end
    push_iss(G_IF, 1'b0, 18'h3FFFF, 16'h0000, 1);
    push_cpl(G_IF, 1'b1, 16'h1234, 1'b0);
    for (int i = 4; i < 6; i++) begin
      push_iss(G_EXE, 1'b0, 18'(32'h100 + i), 16'h0000, 1);
      push_cpl(G_EXE, 1'b1, 16'h1234, 1'b0);
    end
    fork
      begin
        for (int i = 0; i < 6; i++) run_exe(1'b0, 18'(32'h100 + i), 16'h0000);
      end
      run_if(18'h3FFFF);
    join

    // Timeout on an exe read, then sticky error through good accesses
    resp_delay = 0;
    push_iss(G_EXE, 1'b0, 18'h00ABC, 16'h0000, 15);
    push_cpl(G_EXE, 1'b1, 16'hFFFF, 1'b1);
    run_exe(1'b0, 18'h00ABC, 16'h0000);
    resp_delay = 3; resp_data = 16'h7777;
    push_iss(G_IF, 1'b0, 18'h00555, 16'h0000, 3);
    push_cpl(G_IF, 1'b1, 16'h7777, 1'b1);
    run_if(18'h00555);
    push_iss(G_EXE, 1'b1, 18'h00777, 16'h4242, 3);
    push_cpl(G_EXE, 1'b0, 16'h0000, 1'b1);
    run_exe(1'b1, 18'h00777, 16'h4242);

    // Spurious mem_done in IDLE, then in RESP
    repeat (2) @(negedge clk);
    spur_req++;
    repeat (3) @(negedge clk);
    check("spur_idle_busy", 32'(busy), 32'd0);
    check("spur_idle_exe_rdata", 32'(bus.exe_rdata), 32'(exp_exe));
    check("spur_idle_if_rdata", 32'(bus.if_rdata), 32'(exp_if));
    spur_resp = 1'b1;
    resp_delay = 2; resp_data = 16'h0F0F;
    push_iss(G_EXE, 1'b0, 18'h0000F, 16'h0000, 2);
    push_cpl(G_EXE, 1'b1, 16'h0F0F, 1'b1);
    run_exe(1'b0, 18'h0000F, 16'h0000);
    repeat (3) @(negedge clk);
    spur_resp = 1'b0;
    check("spur_resp_exe_rdata", 32'(bus.exe_rdata), 32'h0F0F);
    check("spur_resp_idle", 32'({bus.mem_req, busy}), 32'd0);

    // Reset in the middle of WAIT, then a fresh exe write
    resp_delay = 0;
    push_iss(G_EXE, 1'b1, 18'h2AAAA, 16'h1357, -1);
    @(negedge clk);
    bus.exe_req = 1'b1; bus.exe_we = 1'b1; bus.exe_addr = 18'h2AAAA; bus.exe_wdata = 16'h1357;
    repeat (4) @(negedge clk);
    check("pre_rst_req", 32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(bus.mem_req), 32'd0);
    check("async_rst_status", 32'({grant, busy, timeout_err}), 32'd0);
    bus.exe_req = 1'b0;
    exp_exe = '0; exp_if = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    resp_delay = 2;
    push_iss(G_EXE, 1'b1, 18'h01234, 16'h9ABC, 2);
    push_cpl(G_EXE, 1'b0, 16'h0000, 1'b0);
    run_exe(1'b1, 18'h01234, 16'h9ABC);

    repeat (4) @(negedge clk);
    check("iss_q_drained", 32'(iss_q.size()), 32'd0);
    check("cpl_q_drained", 32'(cpl_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-way arbiter and access sequencer for one single-port external RAM. It sits between the bootloader init-write path, the EXE-stage data path and the IF fetch path on one side, and one RAM access controller on the other. It serialises requests with fixed priority and an IF anti-starvation rule. It presents a registered req/done handshake in both directions and flags memory accesses that hang.

## Interface
Parameters:
- ADDR_W, 18, RAM address width
- DATA_W, 16, RAM data width
- TIMEOUT, 15, cycles in WAIT without mem_done before abort (≥1)
- STARVE_LIMIT, 4, consecutive EXE grants while IF is pending before IF is forced (≥1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- init_req  in  1  bootloader write request, level, held until init_done
- init_addr  in  ADDR_W  init write address
- init_wdata  in  DATA_W  init write data
- exe_req  in  1  EXE access request, level, held until exe_done
- exe_we  in  1  1 = write, 0 = read
- exe_addr  in  ADDR_W  EXE address
- exe_wdata  in  DATA_W  EXE write data
- if_req  in  1  fetch read request, level, held until if_done
- if_addr  in  ADDR_W  fetch address
- init_done, exe_done, if_done  out  1 each  one-cycle completion pulses
- exe_rdata, if_rdata  out  DATA_W  read result, valid in the done cycle and held until the next completion to that port
- mem_req  out  1  downstream request, registered
- mem_we  out  1  downstream write enable
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_done  in  1  downstream completion, sampled only in WAIT
- mem_rdata  in  DATA_W  downstream read data, valid with mem_done
- grant  out  2  00 none, 01 init, 10 exe, 11 if; nonzero in WAIT and RESP only
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky, set on any abort

## Operation
- FSM has three states: IDLE, WAIT and RESP. All outputs are registered.
- IDLE: evaluate requests. Winner order:
  - init_req wins first.
  - Otherwise, if if_req && exe_req && starve_cnt == STARVE_LIMIT, IF wins.
  - Otherwise exe_req wins, then if_req.
- On a win, at the edge:
  - latch grant, mem_addr, mem_wdata and mem_we (init = 1, exe = exe_we, if = 0)
  - set mem_req = 1 and go to WAIT.
- Starvation counter starve_cnt (0..STARVE_LIMIT):
  - At an EXE grant with if_req high, it increments, saturating.
  - At an IF grant, or any grant with if_req low, it clears to 0.
- WAIT: mem_req, mem_addr, mem_wdata and mem_we are held stable. The wait counter increments each cycle.
  - If mem_done = 1: at that edge capture mem_rdata into the granted port's rdata (reads only), set mem_req = 0, pulse the granted done = 1 and go to RESP.
  - Otherwise, if the wait counter reaches TIMEOUT: set mem_req = 0, load rdata with all-ones (reads), pulse done, set timeout_err = 1 and go to RESP.
- RESP: the done pulse is high for this one cycle. The next edge clears done and grant and returns to IDLE.
- Requesters deassert req on the edge at which they see done. IDLE therefore never re-serves a completed request.
- mem_done outside WAIT is ignored.
- init writes never update exe_rdata or if_rdata. exe writes do not update exe_rdata.

## Timing
- Request seen in IDLE at cycle 0 → mem_req high from cycle 1.
- mem_done in cycle k (k≥1) → done pulse in cycle k+1, mem_req low in cycle k+1 → IDLE in cycle k+2.
- Minimum latency from req to done is 2 cycles. Minimum back-to-back issue interval is 3 cycles.
- Timeout: with no mem_done, mem_req is high for exactly TIMEOUT cycles (cycles 1..TIMEOUT), and done pulses in cycle TIMEOUT+1.
- Reset (async, any state, including mid-WAIT) leaves every output at 0 and clears everything:
  - outputs: mem_req, mem_we, mem_addr, mem_wdata, all done pulses, exe_rdata, if_rdata, grant, busy, timeout_err
  - internal: state = IDLE, starve_cnt = 0, wait counter = 0
- The first grant after reset release is possible on the first rising edge with rst = 1.

## Test plan
- Single IF read: if_req with if_addr = 0x00123; mem_done 1 cycle after mem_req with mem_rdata = 0xBEEF → mem_addr = 0x00123 and mem_we = 0 while mem_req is high; if_done pulses once; if_rdata = 0xBEEF; grant = 11 in WAIT/RESP.
- Simultaneous init_req, exe_req and if_req → served in order init, exe, if (grant 01, 10, 11); each done is a single pulse; mem_we = 1 for init.
- exe_req held continuously (re-raised after each done) with if_req pending, STARVE_LIMIT = 4 → exactly 4 EXE grants, then the IF grant, then starve_cnt = 0 and EXE resumes.
- mem_done never asserted, TIMEOUT = 15 → mem_req high for exactly 15 cycles; exe_done pulses in cycle 16 with exe_rdata = 0xFFFF (read); timeout_err = 1 and stays set through later good accesses.
- rst low mid-WAIT with mem_req = 1 → mem_req, busy and grant are 0 immediately (async); no done pulse appears; after release, a fresh exe write completes normally with mem_wdata = exe_wdata.
- Spurious mem_done in IDLE or RESP → no done pulse, no rdata change.
